// File: rtl/cpu_control_unit_if.sv
// Control-strobe bundle between cpu_control_unit (master) and the 4-bit datapath (slave).
interface cpu_control_unit_if;
    logic [15:0] instr;
    logic [1:0]  operato;
    logic        subtract;
    logic        reg_rw;
    logic        mem_rw;
    logic        wb_sel;
    logic        pc_inc;
    logic        pc_load;
    logic [3:0]  pc_target;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [1:0]  rd;
    logic [3:0]  mem_addr;
    logic        halted;
    logic        illegal;

    modport master (
        input  instr,
        output operato, subtract, reg_rw, mem_rw, wb_sel, pc_inc, pc_load,
        output pc_target, rs1, rs2, rd, mem_addr, halted, illegal
    );

    modport slave (
        output instr,
        input  operato, subtract, reg_rw, mem_rw, wb_sel, pc_inc, pc_load,
        input  pc_target, rs1, rs2, rd, mem_addr, halted, illegal
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle Moore control FSM for the 4-bit CPU datapath.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into HALTED instead of skipping them.
module cpu_control_unit (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    cpu_control_unit_if.master    bus
);
    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalted
    } state_e;

    localparam logic [3:0] OpAnd  = 4'd0;
    localparam logic [3:0] OpOr   = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpSub  = 4'd3;
    localparam logic [3:0] OpSlt  = 4'd4;
    localparam logic [3:0] OpLd   = 4'd5;
    localparam logic [3:0] OpSt   = 4'd6;
    localparam logic [3:0] OpJmp  = 4'd7;
    localparam logic [3:0] OpHalt = 4'd15;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;
    logic [3:0]  opcode;
    logic        is_illegal;

    assign opcode     = ir_q[15:12];
    assign is_illegal = opcode[3] && (opcode != OpHalt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        illegal_d    = illegal_q;
        bus.operato  = 2'd0;
        bus.subtract = 1'b0;
        bus.reg_rw   = 1'b1;
        bus.mem_rw   = 1'b1;
        bus.wb_sel   = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.pc_load  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                ir_d       = bus.instr;
                bus.pc_inc = 1'b1;
                state_d    = StDecode;
            end
            StDecode: begin
                if (opcode == OpHalt) begin
                    state_d = StHalted;
                end else if (is_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = StHalted;
`else
                    state_d   = StFetch;
`endif
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                unique case (opcode)
                    OpAnd: begin bus.operato = 2'd0; state_d = StWb; end
                    OpOr:  begin bus.operato = 2'd1; state_d = StWb; end
                    OpAdd: begin bus.operato = 2'd2; state_d = StWb; end
                    OpSub: begin bus.operato = 2'd2; bus.subtract = 1'b1; state_d = StWb; end
                    OpSlt: begin bus.operato = 2'd3; state_d = StWb; end
                    OpLd, OpSt: begin bus.operato = 2'd2; state_d = StMem; end
                    OpJmp: begin bus.pc_load = 1'b1; state_d = StFetch; end
                    // DECODE never routes HALT or illegal opcodes here.
                    default: state_d = StFetch;
                endcase
            end
            StMem: begin
                bus.mem_rw = (opcode == OpLd);
                state_d    = (opcode == OpLd) ? StWb : StFetch;
            end
            StWb: begin
                bus.reg_rw = 1'b0;
                bus.wb_sel = (opcode == OpLd);
                state_d    = StFetch;
            end
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    assign bus.pc_target = ir_q[11:8];
    assign bus.mem_addr  = ir_q[11:8];
    assign bus.rd        = ir_q[5:4];
    assign bus.rs2       = ir_q[3:2];
    assign bus.rs1       = ir_q[1:0];
    assign bus.halted    = (state_q == StHalted);
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed vector table, corner sequences, random model.
module tb_cpu_control_unit;
    logic clk;
    logic reset;
    logic start;
    cpu_control_unit_if bus ();

    cpu_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {bus.reg_rw, bus.mem_rw, bus.wb_sel, bus.pc_inc, bus.pc_load,
                bus.halted, bus.illegal};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0] ins;
        int          lat;
        logic        chk_op;
        logic [1:0]  op;
        logic        sub;
        logic        reg_wr;
        logic        wbs;
        logic        mem_wr;
        logic        pc_ld;
        logic        end_halt;
        logic        end_ill;
    } vec_t;

    vec_t vecs[12];

    task automatic run_one(input int idx, input vec_t v);
        int         lat = 99;
        logic [1:0] op3 = 2'bxx;
        logic       sub3 = 1'bx;
        logic       reg_wr = 1'b0, wbs = 1'b0, mem_wr = 1'b0, pc_ld = 1'b0, overlap = 1'b0;
        logic [3:0] maddr = 4'd0, tgt = 4'd0;
        logic       end_halt = 1'b0, end_ill = 1'b0;
        string      p = $sformatf("vec%0d(%h)", idx, v.ins);
        do_reset();
        start     = 1'b1;
        bus.instr = v.ins;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                chk({p, " pc_inc in FETCH"}, 32'(bus.pc_inc), 32'd1);
            end
            if (c == 3) begin op3 = bus.operato; sub3 = bus.subtract; end
            if (!bus.reg_rw) begin reg_wr = 1'b1; wbs = bus.wb_sel; end
            if (!bus.mem_rw) begin mem_wr = 1'b1; maddr = bus.mem_addr; end
            if (bus.pc_load) begin pc_ld = 1'b1; tgt = bus.pc_target; end
            if (bus.pc_inc && bus.pc_load) overlap = 1'b1;
            if (c > 1 && (bus.pc_inc || bus.halted)) begin
                lat = c - 1; end_halt = bus.halted; end_ill = bus.illegal;
                break;
            end
        end
        chk({p, " latency"}, 32'(lat), 32'(v.lat));
        if (v.chk_op) begin
            chk({p, " operato"}, 32'(op3), 32'(v.op));
            chk({p, " subtract"}, 32'(sub3), 32'(v.sub));
        end
        chk({p, " reg write seen"}, 32'(reg_wr), 32'(v.reg_wr));
        if (v.reg_wr) chk({p, " wb_sel"}, 32'(wbs), 32'(v.wbs));
        chk({p, " mem write seen"}, 32'(mem_wr), 32'(v.mem_wr));
        if (v.mem_wr) chk({p, " mem_addr"}, 32'(maddr), 32'(v.ins[11:8]));
        chk({p, " pc_load seen"}, 32'(pc_ld), 32'(v.pc_ld));
        if (v.pc_ld) chk({p, " pc_target"}, 32'(tgt), 32'(v.ins[11:8]));
        chk({p, " pc_inc/pc_load overlap"}, 32'(overlap), 32'd0);
        chk({p, " halted at end"}, 32'(end_halt), 32'(v.end_halt));
        chk({p, " illegal at end"}, 32'(end_ill), 32'(v.end_ill));
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic        last;
        logic        op_care;
        logic [1:0]  op;
        logic        sub;
        logic        reg_rw;
        logic        mem_rw;
        logic        wb_sel;
        logic        pc_inc;
        logic        pc_load;
        logic        halted;
        logic        illegal;
        logic [15:0] ir;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] insq[$];
    logic [15:0] m_ir;
    logic        m_halted;
    logic        m_illegal;

    function automatic exp_t mk();
        exp_t e = '0;
        e.op_care = 1'b1;
        e.reg_rw  = 1'b1;
        e.mem_rw  = 1'b1;
        e.ir      = m_ir;
        return e;
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, FETCH through its last state.
    task automatic model_instr(input logic [15:0] ins);
        exp_t       e;
        logic [3:0] opc = ins[15:12];
        e = mk(); e.pc_inc = 1'b1; expq.push_back(e);
        m_ir = ins;
        e = mk(); expq.push_back(e);
        if (opc == 4'hF || (opc >= 4'd8 && Trap)) begin
            m_halted  = 1'b1;
            m_illegal = (opc != 4'hF);
            expq[expq.size()-1].last = 1'b1;
            return;
        end
        if (opc >= 4'd8) begin
            expq[expq.size()-1].last = 1'b1;
            return;
        end
        e = mk();
        case (opc)
            4'd0: e.op = 2'd0;
            4'd1: e.op = 2'd1;
            4'd2: e.op = 2'd2;
            4'd3: begin e.op = 2'd2; e.sub = 1'b1; end
            4'd4: e.op = 2'd3;
            4'd5, 4'd6: e.op = 2'd2;
            default: begin e.op_care = 1'b0; e.pc_load = 1'b1; e.last = 1'b1; end
        endcase
        expq.push_back(e);
        if (opc == 4'd7) return;
        if (opc == 4'd5 || opc == 4'd6) begin
            e = mk(); e.op_care = 1'b0; e.mem_rw = (opc == 4'd5); e.last = (opc == 4'd6);
            expq.push_back(e);
            if (opc == 4'd6) return;
        end
        e = mk(); e.op_care = 1'b0; e.reg_rw = 1'b0; e.wb_sel = (opc == 4'd5); e.last = 1'b1;
        expq.push_back(e);
    endtask

    task automatic run_random(input int n_instr);
        exp_t        e;
        logic [15:0] ins;
        int          cyc = 0;
        m_ir = '0; m_halted = 1'b0; m_illegal = 1'b0;
        expq.delete(); insq.delete();
        for (int i = 0; i < n_instr && !m_halted; i++) begin
            ins = 16'($urandom);
            ins[15:12] = (i == n_instr - 1) ? 4'hF : 4'($urandom_range(0, 14));
            insq.push_back(ins);
            model_instr(ins);
        end
        for (int i = 0; i < 6; i++) begin
            e = mk(); e.halted = 1'b1; e.illegal = m_illegal; expq.push_back(e);
        end
        do_reset();
        start     = 1'b1;
        bus.instr = insq.pop_front();
        while (expq.size() > 0) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            e = expq.pop_front();
            chk($sformatf("rand[%0d] strobes", cyc), 32'(strobes()),
                32'({e.reg_rw, e.mem_rw, e.wb_sel, e.pc_inc, e.pc_load, e.halted, e.illegal}));
            if (e.op_care)
                chk($sformatf("rand[%0d] alu", cyc), 32'({bus.operato, bus.subtract}),
                    32'({e.op, e.sub}));
            chk($sformatf("rand[%0d] ir fields", cyc),
                32'({bus.pc_target, bus.mem_addr, bus.rd, bus.rs2, bus.rs1}),
                32'({e.ir[11:8], e.ir[11:8], e.ir[5:4], e.ir[3:2], e.ir[1:0]}));
            if (e.last && insq.size() > 0) bus.instr = insq.pop_front();
            cyc++;
        end
        start = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        bus.instr = '0;

        // Reset then idle: nothing moves without start.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("idle[%0d] strobes", c), 32'(strobes()), 32'b1100000);
            chk($sformatf("idle[%0d] alu", c), 32'({bus.operato, bus.subtract}), 32'd0);
        end

        //          ins      lat op? op  sub rw  wbs mw  pcl halt   ill
        vecs[0]  = '{16'h0123, 4, 1, 2'd0, 0, 1, 0, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{16'h1231, 4, 1, 2'd1, 0, 1, 0, 0, 0, 1'b0, 1'b0};
        vecs[2]  = '{16'h2026, 4, 1, 2'd2, 0, 1, 0, 0, 0, 1'b0, 1'b0};
        vecs[3]  = '{16'h3015, 4, 1, 2'd2, 1, 1, 0, 0, 0, 1'b0, 1'b0};
        vecs[4]  = '{16'h40E7, 4, 1, 2'd3, 0, 1, 0, 0, 0, 1'b0, 1'b0};
        vecs[5]  = '{16'h5A10, 5, 1, 2'd2, 0, 1, 1, 0, 0, 1'b0, 1'b0};
        vecs[6]  = '{16'h6302, 4, 1, 2'd2, 0, 0, 0, 1, 0, 1'b0, 1'b0};
        vecs[7]  = '{16'h7C00, 3, 0, 2'd0, 0, 0, 0, 0, 1, 1'b0, 1'b0};
        vecs[8]  = '{16'h7F3F, 3, 0, 2'd0, 0, 0, 0, 0, 1, 1'b0, 1'b0};
        vecs[9]  = '{16'hF000, 2, 0, 2'd0, 0, 0, 0, 0, 0, 1'b1, 1'b0};
        vecs[10] = '{16'h9000, 2, 0, 2'd0, 0, 0, 0, 0, 0, Trap, Trap};
        vecs[11] = '{16'hE5C3, 2, 0, 2'd0, 0, 0, 0, 0, 0, Trap, Trap};
        for (int i = 0; i < 12; i++) run_one(i, vecs[i]);

        // HALT is absorbing: start pulses afterwards do nothing.
        run_one(9, vecs[9]);
        for (int c = 0; c < 8; c++) begin
            start = 1'(c[0]);
            @(negedge clk);
            chk($sformatf("halt_sticky[%0d] halted,pc_inc", c),
                32'({bus.halted, bus.pc_inc, bus.reg_rw, bus.mem_rw}), 32'b1011);
        end
        start = 1'b0;

        // Reset during WB of SUB aborts the write and clears IR.
        do_reset();
        start     = 1'b1;
        bus.instr = 16'h3015;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("midwb reg_rw in WB", 32'(bus.reg_rw), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("midwb strobes after reset", 32'(strobes()), 32'b1100000);
        chk("midwb ir cleared", 32'({bus.mem_addr, bus.rd, bus.rs2, bus.rs1}), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("midwb idle[%0d]", c), 32'(strobes()), 32'b1100000);
        end

        for (int r = 0; r < 20; r++) run_random(int'($urandom_range(3, 12)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle control FSM that drives the 4-bit CPU datapath. It fetches a 16-bit instruction word from instruction memory and latches it into an internal instruction register (IR). It then sequences ALU operation select, register-file read/write, data-memory read/write, write-back select and PC increment/load. The datapath consumes these strobes; until now a bench has driven them by hand.

## Interface
Parameters: none.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse in IDLE begins execution.
- instr  input  16  instruction memory read data for the current PC; combinational.
- operato  output  2  ALU op select: 0 AND, 1 OR, 2 ADD/SUB, 3 SLT.
- subtract  output  1  ALU subtract when operato=2.
- reg_rw  output  1  register file: 1 read, 0 write.
- mem_rw  output  1  data memory: 1 read, 0 write.
- wb_sel  output  1  write-back source: 0 ALU result, 1 memory read data.
- pc_inc  output  1  PC increment strobe.
- pc_load  output  1  PC load strobe.
- pc_target  output  4  PC load value.
- rs1, rs2, rd  output  2 each  register indices from IR.
- mem_addr  output  4  data memory address, IR[11:8].
- halted  output  1  high in HALTED state.
- illegal  output  1  sticky illegal-opcode flag.

## Operation
- Instruction format: IR[15:12] opcode, IR[11:8] address/target, IR[7:6] reserved (ignored), IR[5:4] rd, IR[3:2] rs2, IR[1:0] rs1.
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT: all R-type, result goes to rd.
  - 5 LD: rd <= mem[addr].
  - 6 ST: mem[addr] <= rs1.
  - 7 JMP: PC <= target.
  - 15 HALT.
  - 8–14 illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED.
- Transitions:
  - IDLE to FETCH when start=1; otherwise stay in IDLE.
  - FETCH: IR <= instr; pc_inc=1; go to DECODE.
  - DECODE: reg_rw=1 so the register file registers rs1/rs2; go to EXEC.
    - If HALT: go to HALTED.
    - If illegal: go to FETCH (NOP); see Configuration.
  - EXEC: operato/subtract driven per opcode.
    - R-type: go to WB.
    - LD/ST: go to MEM.
    - JMP: pc_load=1, pc_target=IR[11:8], then go to FETCH.
  - MEM: mem_rw=0 for ST, 1 for LD.
    - ST: go to FETCH.
    - LD: go to WB.
  - WB: reg_rw=0; wb_sel=1 for LD, 0 for R-type; go to FETCH.
  - HALTED: absorbing; only reset exits. start is ignored.
- ALU mapping:
  - AND: operato=0.
  - OR: operato=1.
  - ADD: operato=2, subtract=0.
  - SUB: operato=2, subtract=1.
  - SLT: operato=3.
  - LD/ST: operato=2, subtract=0; result is don't-care.
- Outputs are Moore: functions of state and IR only. Defaults in every state not listed above: reg_rw=1, mem_rw=1, pc_inc=0, pc_load=0, wb_sel=0, operato=0, subtract=0.
- rs1/rs2/rd/mem_addr/pc_target continuously reflect IR.
- start asserted outside IDLE has no effect.

## Timing
- Reset (synchronous, dominant over all other inputs):
  - State=IDLE, IR=0, illegal=0, halted=0.
  - All strobes take their default values: reg_rw=1, mem_rw=1, pc_inc=0, pc_load=0, wb_sel=0, operato=0, subtract=0.
- Reset mid-instruction aborts the instruction. No write strobe (reg_rw=0 or mem_rw=0) may appear in the cycle after reset is sampled.
- Instruction latency, counting FETCH through the last state before the next FETCH:
  - R-type: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - JMP: 3 cycles.
  - HALT: 2 cycles, then HALTED.
  - Illegal (macro undefined): 2 cycles.
- pc_inc and pc_load are each exactly one cycle wide and never high together.
- instr is sampled only at the FETCH clock edge.
- pc_target is a 4-bit value; JMP to 15 is legal. PC wrap from 15 to 0 on increment is the PC's own behaviour.
- reg_rw=0 occurs only in WB. mem_rw=0 occurs only in MEM of ST.

## Configuration
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE sets illegal=1 and goes to HALTED; halted=1 from the next cycle.
- Undefined: an illegal opcode is a 2-cycle NOP (DECODE to FETCH), and illegal remains 0 permanently.

## Test plan
- Reset then idle: hold reset 2 cycles, release, start=0 for 5 cycles -> state IDLE; reg_rw=1, mem_rw=1, pc_inc=0, halted=0 throughout.
- ADD: start with instr=0x2026 (rd=2, rs2=1, rs1=2) -> pc_inc in cycle 1; operato=2, subtract=0 in cycle 3; reg_rw=0, wb_sel=0 in cycle 4; FETCH in cycle 5.
- LD/ST: instr=0x5A10 -> mem_rw=1 in MEM, reg_rw=0 and wb_sel=1 in WB (5 cycles). instr=0x6302 -> mem_rw=0 with mem_addr=3 in MEM; no reg_rw=0 at any point (4 cycles).
- JMP and HALT: instr=0x7C00 -> pc_load=1 and pc_target=12 in cycle 3, pc_inc=0 that cycle. Next instr=0xF000 -> halted=1 permanently; later start pulses have no effect.
- Illegal: instr=0x9000 -> with CTRL_ILLEGAL_TRAP_EN, illegal=1 and halted=1. Without it, FETCH follows 2 cycles later and illegal stays 0.
- Reset mid-WB of SUB (instr=0x3015): assert reset in the WB cycle -> next cycle state=IDLE, reg_rw=1, IR=0, with no further write strobes.
